// File: rtl/fetch_stage_pkg.sv
// Shared defines for the fetch stage: default widths, reset PC and NOP encoding.
package fetch_stage_pkg;

    localparam int unsigned WORD_LEN_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

endpackage

// File: rtl/fetch_reg.sv
// Parameterised register with synchronous clear (to CLR_VAL) and load-enable.
// Ports: clk, clr (sync clear, wins over en), en (load enable), d, q.
module fetch_reg import fetch_stage_pkg::*; #(
    parameter int unsigned W       = WORD_LEN_DEF,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, PC+4 adder, branch redirect and IF/ID register.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   freeze            - hazard stall: hold PC and IF/ID
//   branch_taken      - redirect request from ID, with branch_target
//   fetch_addr        - current PC to instruction memory (combinational from PC register)
//   fetch_instr       - instruction word returned for fetch_addr
//   ifid_instr, ifid_pc_plus4, ifid_valid - registered IF/ID payload
module fetch_stage import fetch_stage_pkg::*; #(
    parameter int unsigned         WORD_LEN = WORD_LEN_DEF,
    parameter logic [WORD_LEN-1:0] RESET_PC = WORD_LEN'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_target,
    output logic [WORD_LEN-1:0] fetch_addr,
    input  logic [WORD_LEN-1:0] fetch_instr,
    output logic [WORD_LEN-1:0] ifid_instr,
    output logic [WORD_LEN-1:0] ifid_pc_plus4,
    output logic                ifid_valid
);

    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] pc_plus4;
    logic [WORD_LEN-1:0] pc_next;
    logic                advance;
    logic                bubble;
    logic                ifid_clr;
    logic [1:0]          unused_target_lsbs;

    // Target low bits are dropped so the PC stays word aligned.
    assign unused_target_lsbs = branch_target[1:0];

    assign pc_plus4 = pc + WORD_LEN'(4);
    assign pc_next  = branch_taken ? {branch_target[WORD_LEN-1:2], 2'b00} : pc_plus4;

    // freeze outranks branch_taken; a redirect only happens when not frozen.
    assign advance  = ~freeze;
    assign bubble   = advance & branch_taken;
    assign ifid_clr = rst | bubble;

    // fetch_addr depends only on the PC register, never on freeze/branch inputs.
    assign fetch_addr = pc;

    fetch_reg #(
        .W       (WORD_LEN),
        .CLR_VAL (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .clr (rst),
        .en  (advance),
        .d   (pc_next),
        .q   (pc)
    );

    fetch_reg #(
        .W       (WORD_LEN),
        .CLR_VAL (WORD_LEN'(NOP_INSTR))
    ) u_ifid_instr_reg (
        .clk (clk),
        .clr (ifid_clr),
        .en  (advance),
        .d   (fetch_instr),
        .q   (ifid_instr)
    );

    fetch_reg #(
        .W       (WORD_LEN),
        .CLR_VAL ('0)
    ) u_ifid_pc4_reg (
        .clk (clk),
        .clr (ifid_clr),
        .en  (advance),
        .d   (pc_plus4),
        .q   (ifid_pc_plus4)
    );

    fetch_reg #(
        .W       (1),
        .CLR_VAL (1'b0)
    ) u_ifid_valid_reg (
        .clk (clk),
        .clr (ifid_clr),
        .en  (advance),
        .d   (1'b1),
        .q   (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table plus randomized run
// against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;

    fetch_stage #(
        .WORD_LEN (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fetch_addr    (fetch_addr),
        .fetch_instr   (fetch_instr),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: fixed words at 0..12, address-derived elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'h0000_0011;
            32'h4:   mem_word = 32'h0000_0022;
            32'h8:   mem_word = 32'h0000_0033;
            32'hC:   mem_word = 32'h0000_0044;
            default: mem_word = a ^ 32'hDEAD_0000;
        endcase
    endfunction

    assign fetch_instr = mem_word(fetch_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Model: apply the spec's edge rules in priority order.
    task automatic model_edge(input logic r, input logic f, input logic b, input logic [31:0] t);
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (f) begin
            // hold everything
        end else if (b) begin
            m_pc = t & ~32'h3; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = mem_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
        end
    endtask

    // Drive inputs, clock once, update the model, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] t);
        rst = r; freeze = f; branch_taken = b; branch_target = t;
        @(posedge clk);
        model_edge(r, f, b, t);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic        f;
        logic        b;
        logic [31:0] t;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[21];

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;

        //            r     f     b     target         addr           instr                     pc4            valid
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,                    32'h0,         1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'h11,                   32'h4,         1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         32'h22,                   32'h8,         1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h8,         32'h22,                   32'h8,         1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h8,         32'h22,                   32'h8,         1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hC,         32'h33,                   32'hC,         1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h10,        32'h44,                   32'h10,        1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,                    32'h0,         1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'h11,                   32'h4,         1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         32'h22,                   32'h8,         1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hC,         32'h33,                   32'hC,         1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h41,        32'h40,        32'h0,                    32'h0,         1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h44,        mem_word(32'h40),         32'h44,        1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h100,       32'h44,        mem_word(32'h40),         32'h44,        1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h102,       32'h100,       32'h0,                    32'h0,         1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,                    32'h0,         1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         mem_word(32'hFFFF_FFFC),  32'h0,         1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h40,        32'h40,        32'h0,                    32'h0,         1'b0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 32'h80,        32'h0,         32'h0,                    32'h0,         1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 32'h80,        32'h0,         32'h0,                    32'h0,         1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'h11,                   32'h4,         1'b1};

        #2;
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].r, vecs[i].f, vecs[i].b, vecs[i].t);
            chk($sformatf("vec%0d_addr", i),  fetch_addr,    vecs[i].e_addr);
            chk($sformatf("vec%0d_instr", i), ifid_instr,    vecs[i].e_instr);
            chk($sformatf("vec%0d_pc4", i),   ifid_pc_plus4, vecs[i].e_pc4);
            chk($sformatf("vec%0d_valid", i), 32'(ifid_valid), 32'(vecs[i].e_valid));
        end

        // fetch_addr must not react to freeze/branch changes within a cycle.
        begin
            logic [31:0] held;
            held = fetch_addr;
            freeze = 1'b1; branch_taken = 1'b1; branch_target = 32'h1230;
            #2;
            chk("no_comb_path_a", fetch_addr, held);
            freeze = 1'b0;
            #1;
            chk("no_comb_path_b", fetch_addr, held);
        end

        // Randomized run against the model.
        for (int n = 0; n < 600; n++) begin
            logic r, f, b;
            logic [31:0] t;
            r = ($urandom_range(0, 49) == 0);
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 4) == 0);
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                            : 32'($urandom_range(0, 255));
            step(r, f, b, t);
            chk($sformatf("rnd%0d_addr", n),  fetch_addr,    m_pc);
            chk($sformatf("rnd%0d_instr", n), ifid_instr,    m_instr);
            chk($sformatf("rnd%0d_pc4", n),   ifid_pc_plus4, m_pc4);
            chk($sformatf("rnd%0d_valid", n), 32'(ifid_valid), 32'(m_valid));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
